// File: rtl/dac_playback_ctrl_pkg.sv
// Shared encodings and default sizes for the DAC playback controller.
package dac_playback_ctrl_pkg;

    localparam int DATA_W_DEF     = 10;
    localparam int FIFO_AW_DEF    = 4;
    localparam int DIV_W_DEF      = 16;
    localparam int SETTLE_CYC_DEF = 64;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_e;

endpackage

// File: rtl/dac_playback_ctrl_if.sv
// Register-side and DAC-pin signal bundle of the playback controller.
// master = register/IPIF side, slave = the controller itself.
interface dac_playback_ctrl_if #(
    parameter int DATA_W  = dac_playback_ctrl_pkg::DATA_W_DEF,
    parameter int FIFO_AW = dac_playback_ctrl_pkg::FIFO_AW_DEF,
    parameter int DIV_W   = dac_playback_ctrl_pkg::DIV_W_DEF
);
    logic                Cfg_Enable;
    logic                Cfg_IQ_Mode;
    logic [DIV_W-1:0]    Cfg_Divider;
    logic                Smp_Wr;
    logic [2*DATA_W-1:0] Smp_Data;
    logic                Smp_Full;
    logic [FIFO_AW:0]    Smp_Level;
    logic                Sts_Clr;
    logic [1:0]          Sts_State;
    logic                Sts_Underrun;
    logic                Sts_Overflow;
    logic [DATA_W-1:0]   IP2DAC_Data;
    logic                IP2DAC_DCLKIO;
    logic                IP2DAC_PWRDN;
    logic                IP2DAC_OpEnI;
    logic                IP2DAC_OpEnQ;

    modport master (
        output Cfg_Enable, Cfg_IQ_Mode, Cfg_Divider, Smp_Wr, Smp_Data, Sts_Clr,
        input  Smp_Full, Smp_Level, Sts_State, Sts_Underrun, Sts_Overflow,
        input  IP2DAC_Data, IP2DAC_DCLKIO, IP2DAC_PWRDN, IP2DAC_OpEnI, IP2DAC_OpEnQ
    );

    modport slave (
        input  Cfg_Enable, Cfg_IQ_Mode, Cfg_Divider, Smp_Wr, Smp_Data, Sts_Clr,
        output Smp_Full, Smp_Level, Sts_State, Sts_Underrun, Sts_Overflow,
        output IP2DAC_Data, IP2DAC_DCLKIO, IP2DAC_PWRDN, IP2DAC_OpEnI, IP2DAC_OpEnQ
    );
endinterface

// File: rtl/dac_playback_ctrl_fifo.sv
// Generic synchronous FIFO with show-ahead read data; full is registered.
// Writes while full are dropped; pops while empty are ignored.
module dac_playback_ctrl_fifo #(
    parameter int W  = 20,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         empty,
    output logic [AW:0]  level
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   lvl_d;
    logic          push, pop;

    assign push   = wr_vld && !full;
    assign pop    = rd_rdy && !empty;
    assign empty  = (level == '0);
    assign rd_dat = mem[rd_ptr];

    always_comb begin
        lvl_d = level;
        if (push && !pop)
            lvl_d = level + (AW+1)'(1);
        else if (pop && !push)
            lvl_d = level - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= lvl_d;
            full  <= (lvl_d == LVL_FULL);
        end
    end
endmodule

// File: rtl/dac_playback_ctrl.sv
// DAC sequencer: power-up/settle, paced I/Q slot playback from a local FIFO.
// Popped sample appears on the DAC bus one clock after the pop; underrun repeats the last sample.
module dac_playback_ctrl
    import dac_playback_ctrl_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_AW    = FIFO_AW_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic               Bus2IP_Clk,
    input  logic               Bus2IP_Reset,
    dac_playback_ctrl_if.slave bus
);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    state_e              state, state_d;
    logic [SET_W-1:0]    settle_cnt;
    logic [DIV_W-1:0]    slot_cnt, div_lat;
    logic                primed, iq_lat;
    logic [DATA_W-1:0]   cur_i, cur_q;
    logic                start_i, start_q, slot_end, pop;
    logic                fifo_empty, fifo_full;
    logic [2*DATA_W-1:0] fifo_rdat;
    logic                underrun_r, overflow_r;
    logic [DATA_W-1:0]   data_r, data_d;
    logic                dclk_r, dclk_d, pwrdn_r, pwrdn_d;
    logic                open_i_r, open_i_d, open_q_r, open_q_d;

    dac_playback_ctrl_fifo #(.W(2*DATA_W), .AW(FIFO_AW)) u_fifo (
        .clk    (Bus2IP_Clk),
        .rst    (Bus2IP_Reset),
        .wr_vld (bus.Smp_Wr),
        .wr_dat (bus.Smp_Data),
        .full   (fifo_full),
        .rd_rdy (pop),
        .rd_dat (fifo_rdat),
        .empty  (fifo_empty),
        .level  (bus.Smp_Level)
    );

    assign slot_end = (slot_cnt == div_lat);
    assign pop      = start_i && !fifo_empty;

    // primed is clear only in the first RUN clock, which issues the first pop.
    always_comb begin
        state_d = state;
        start_i = 1'b0;
        start_q = 1'b0;
        case (state)
            ST_OFF: if (bus.Cfg_Enable) state_d = ST_WAKE;
            ST_WAKE: begin
                if (!bus.Cfg_Enable)
                    state_d = ST_OFF;
                else if (settle_cnt == SET_W'(SETTLE_CYC - 1))
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!primed)
                    start_i = 1'b1;
                else if (slot_end) begin
                    start_q = dclk_r;
                    start_i = !dclk_r;
                end
                if (!bus.Cfg_Enable)
                    state_d = ST_STOP;
            end
            default: begin
                if (slot_end) begin
                    start_q = dclk_r;
                    if (!dclk_r)
                        state_d = ST_OFF;
                end
            end
        endcase
    end

    always_comb begin
        pwrdn_d  = pwrdn_r;
        open_i_d = open_i_r;
        open_q_d = open_q_r;
        dclk_d   = dclk_r;
        data_d   = data_r;
        if (state == ST_OFF && state_d == ST_WAKE) begin
            pwrdn_d  = 1'b0;
            open_i_d = 1'b1;
            open_q_d = bus.Cfg_IQ_Mode;
        end
        if (state != ST_OFF && state_d == ST_OFF) begin
            pwrdn_d  = 1'b1;
            open_i_d = 1'b0;
            open_q_d = 1'b0;
            dclk_d   = 1'b0;
        end
        if (start_i) begin
            dclk_d = 1'b1;
            data_d = fifo_empty ? cur_i : fifo_rdat[2*DATA_W-1:DATA_W];
        end else if (start_q) begin
            dclk_d = 1'b0;
            data_d = iq_lat ? cur_q : cur_i;
        end
    end

    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            slot_cnt   <= '0;
            div_lat    <= '0;
            primed     <= 1'b0;
            iq_lat     <= 1'b0;
            cur_i      <= '0;
            cur_q      <= '0;
            underrun_r <= 1'b0;
            overflow_r <= 1'b0;
            data_r     <= '0;
            dclk_r     <= 1'b0;
            pwrdn_r    <= 1'b1;
            open_i_r   <= 1'b0;
            open_q_r   <= 1'b0;
        end else begin
            state      <= state_d;
            settle_cnt <= (state == ST_WAKE) ? settle_cnt + SET_W'(1) : '0;
            if (start_i || start_q) begin
                slot_cnt <= '0;
                div_lat  <= bus.Cfg_Divider;
            end else begin
                slot_cnt <= slot_cnt + DIV_W'(1);
            end
            primed <= (state_d == ST_RUN || state_d == ST_STOP) && (primed || start_i);
            if (state == ST_OFF && state_d == ST_WAKE)
                iq_lat <= bus.Cfg_IQ_Mode;
            if (pop)
                {cur_i, cur_q} <= fifo_rdat;
            underrun_r <= (start_i && fifo_empty) || (underrun_r && !bus.Sts_Clr);
            overflow_r <= (bus.Smp_Wr && fifo_full) || (overflow_r && !bus.Sts_Clr);
            data_r     <= data_d;
            dclk_r     <= dclk_d;
            pwrdn_r    <= pwrdn_d;
            open_i_r   <= open_i_d;
            open_q_r   <= open_q_d;
        end
    end

    assign bus.Smp_Full      = fifo_full;
    assign bus.Sts_State     = state;
    assign bus.Sts_Underrun  = underrun_r;
    assign bus.Sts_Overflow  = overflow_r;
    assign bus.IP2DAC_Data   = data_r;
    assign bus.IP2DAC_DCLKIO = dclk_r;
    assign bus.IP2DAC_PWRDN  = pwrdn_r;
    assign bus.IP2DAC_OpEnI  = open_i_r;
    assign bus.IP2DAC_OpEnQ  = open_q_r;
endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Bench for dac_playback_ctrl: directed scenarios plus randomized playback against a sample-queue model.
module tb_dac_playback_ctrl;
    localparam int DATA_W     = 10;
    localparam int FIFO_AW    = 4;
    localparam int DIV_W      = 16;
    localparam int SETTLE_CYC = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dac_playback_ctrl_if #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) bus ();

    dac_playback_ctrl #(
        .DATA_W(DATA_W), .FIFO_AW(FIFO_AW), .DIV_W(DIV_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .bus          (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; consumes exactly one clock.
    task automatic smp_write(input logic [19:0] d);
        bus.Smp_Wr   = 1'b1;
        bus.Smp_Data = d;
        @(negedge clk);
        bus.Smp_Wr   = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n = 0;
        while (bus.Sts_State != s && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.Sts_State), 32'(s));
    endtask

    // Number of consecutive negedges (from now) on which DCLKIO == v.
    task automatic run_len(input logic v, output int len);
        len = 0;
        while (bus.IP2DAC_DCLKIO == v && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt, h, lo;
        logic [19:0] q[$];
        bus.Cfg_Enable  = 1'b0;
        bus.Cfg_IQ_Mode = 1'b0;
        bus.Cfg_Divider = '0;
        bus.Smp_Wr      = 1'b0;
        bus.Smp_Data    = '0;
        bus.Sts_Clr     = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pwrdn", 32'(bus.IP2DAC_PWRDN), 32'd1);
        check("rst_dclk",  32'(bus.IP2DAC_DCLKIO), 32'd0);
        check("rst_state", 32'(bus.Sts_State), 32'd0);
        check("rst_level", 32'(bus.Smp_Level), 32'd0);
        check("rst_full",  32'(bus.Smp_Full), 32'd0);

        // Power-up timing and single-mode pacing with divider 4
        bus.Cfg_Divider = 16'd4;
        smp_write({10'h155, 10'h0AB});
        smp_write({10'h2AA, 10'h0CD});
        check("t3_level", 32'(bus.Smp_Level), 32'd2);
        bus.Cfg_Enable = 1'b1;
        @(negedge clk);
        check("wake_state", 32'(bus.Sts_State), 32'd1);
        check("wake_pwrdn", 32'(bus.IP2DAC_PWRDN), 32'd0);
        check("wake_openi", 32'(bus.IP2DAC_OpEnI), 32'd1);
        check("wake_openq", 32'(bus.IP2DAC_OpEnQ), 32'd0);
        cnt = 0;
        while (bus.Sts_State != 2'd2 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("settle_len", 32'(cnt), 32'(SETTLE_CYC));
        for (int i = 0; i <= 32; i++) begin
            @(negedge clk);
            check("t3_dclk", 32'(bus.IP2DAC_DCLKIO), 32'(((i / 5) % 2) == 0));
            check("t3_data", 32'(bus.IP2DAC_Data), (i < 10) ? 32'h155 : 32'h2AA);
            if (i == 19) check("udr_before", 32'(bus.Sts_Underrun), 32'd0);
            if (i == 20) check("udr_set", 32'(bus.Sts_Underrun), 32'd1);
            if (i == 21) bus.Sts_Clr = 1'b1;
            if (i == 22) begin
                check("udr_clr", 32'(bus.Sts_Underrun), 32'd0);
                bus.Sts_Clr = 1'b0;
            end
            if (i == 29) bus.Sts_Clr = 1'b1;
            if (i == 30) begin
                check("udr_set_wins", 32'(bus.Sts_Underrun), 32'd1);
                bus.Sts_Clr = 1'b0;
            end
        end

        // Reset held 3 clocks in the middle of RUN
        smp_write({10'h011, 10'h022});
        smp_write({10'h033, 10'h044});
        check("pre_rst_level", 32'(bus.Smp_Level), 32'd2);
        rst = 1'b1;
        bus.Cfg_Enable = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t1_data",  32'(bus.IP2DAC_Data), 32'd0);
        check("t1_dclk",  32'(bus.IP2DAC_DCLKIO), 32'd0);
        check("t1_pwrdn", 32'(bus.IP2DAC_PWRDN), 32'd1);
        check("t1_openi", 32'(bus.IP2DAC_OpEnI), 32'd0);
        check("t1_openq", 32'(bus.IP2DAC_OpEnQ), 32'd0);
        check("t1_state", 32'(bus.Sts_State), 32'd0);
        check("t1_level", 32'(bus.Smp_Level), 32'd0);
        check("t1_udr",   32'(bus.Sts_Underrun), 32'd0);

        // IQ interleave at divider 0
        bus.Cfg_Divider = 16'd0;
        bus.Cfg_IQ_Mode = 1'b1;
        repeat (4) smp_write({10'h3FF, 10'h001});
        check("t4_level", 32'(bus.Smp_Level), 32'd4);
        bus.Cfg_Enable = 1'b1;
        wait_state(2'd2, "t4_run");
        check("t4_openq", 32'(bus.IP2DAC_OpEnQ), 32'd1);
        run_len(1'b0, h);
        check("t4_lead", 32'(h), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check("t4_dclk", 32'(bus.IP2DAC_DCLKIO), 32'((i % 2) == 0));
            check("t4_data", 32'(bus.IP2DAC_Data), (i % 2 == 0) ? 32'h3FF : 32'h001);
            if (i == 0) check("t4_level_3", 32'(bus.Smp_Level), 32'd3);
            if (i == 6) check("t4_level_0", 32'(bus.Smp_Level), 32'd0);
        end
        bus.Cfg_Enable = 1'b0;
        wait_state(2'd0, "t4_off");
        check("t4_pwrdn", 32'(bus.IP2DAC_PWRDN), 32'd1);

        // Overflow on the 17th write, then stop mid slot I
        pulse_reset();
        bus.Cfg_Divider = 16'd3;
        bus.Cfg_IQ_Mode = 1'b0;
        for (int k = 0; k < 17; k++) smp_write({10'(k + 256), 10'(k)});
        check("t6_full", 32'(bus.Smp_Full), 32'd1);
        check("t6_ovf", 32'(bus.Sts_Overflow), 32'd1);
        check("t6_level", 32'(bus.Smp_Level), 32'd16);
        bus.Cfg_Enable = 1'b1;
        wait_state(2'd2, "t6_run");
        run_len(1'b0, h);
        check("t6_lead", 32'(h), 32'd1);
        check("t6_data", 32'(bus.IP2DAC_Data), 32'h100);
        @(negedge clk);
        bus.Cfg_Enable = 1'b0;
        run_len(1'b1, h);
        lo = 0;
        while (!bus.IP2DAC_PWRDN && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check("t6_i_rest", 32'(h), 32'd3);
        check("t6_q_len", 32'(lo), 32'd4);
        check("t6_state", 32'(bus.Sts_State), 32'd0);
        check("t6_dclk", 32'(bus.IP2DAC_DCLKIO), 32'd0);
        check("t6_openi", 32'(bus.IP2DAC_OpEnI), 32'd0);
        check("t6_hold", 32'(bus.IP2DAC_Data), 32'h100);
        check("t6_level_kept", 32'(bus.Smp_Level), 32'd15);
        bus.Sts_Clr = 1'b1;
        @(negedge clk);
        bus.Sts_Clr = 1'b0;
        check("t6_ovf_clr", 32'(bus.Sts_Overflow), 32'd0);

        // Randomized playback checked against a queue of written samples
        pulse_reset();
        for (int it = 0; it < 6; it++) begin
            int n;
            int div;
            logic iq;
            logic [9:0] exp_i;
            n   = $urandom_range(16, 1);
            div = $urandom_range(5, 0);
            iq  = 1'($urandom_range(1, 0));
            q.delete();
            for (int k = 0; k < n; k++) begin
                q.push_back(20'($urandom));
                smp_write(q[k]);
            end
            check("rnd_level", 32'(bus.Smp_Level), 32'(n));
            bus.Cfg_Divider = 16'(div);
            bus.Cfg_IQ_Mode = iq;
            bus.Cfg_Enable  = 1'b1;
            wait_state(2'd2, "rnd_run");
            run_len(1'b0, h);
            check("rnd_lead", 32'(h), 32'd1);
            for (int k = 0; k <= n; k++) begin
                exp_i = (k < n) ? q[k][19:10] : q[n-1][19:10];
                check("rnd_i", 32'(bus.IP2DAC_Data), 32'(exp_i));
                check("rnd_udr", 32'(bus.Sts_Underrun), 32'(k == n));
                if (k == n) break;
                run_len(1'b1, h);
                check("rnd_i_len", 32'(h), 32'(div + 1));
                check("rnd_q", 32'(bus.IP2DAC_Data), iq ? 32'(q[k][9:0]) : 32'(q[k][19:10]));
                run_len(1'b0, lo);
                check("rnd_q_len", 32'(lo), 32'(div + 1));
            end
            bus.Cfg_Enable = 1'b0;
            wait_state(2'd0, "rnd_off");
            check("rnd_pwrdn", 32'(bus.IP2DAC_PWRDN), 32'd1);
            bus.Sts_Clr = 1'b1;
            @(negedge clk);
            bus.Sts_Clr = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
